// File: rtl/gpc_4t_pkg.sv
// Shared types and constants for the gpc multi-thread fetch scheduler.
// Pipe tags carry a thread ID wide enough for the largest supported thread count.
package gpc_4t_pkg;

    localparam int unsigned MAX_THREADS = 16;
    localparam int unsigned MAX_TID_W   = $clog2(MAX_THREADS);

    typedef logic [MAX_TID_W-1:0] t_tid;

    typedef struct packed {
        logic valid;
        t_tid tid;
    } t_pipe_tag;

    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEF_PC_STRIDE = 32'h0000_0400;

endpackage

// File: rtl/gpc_rr_arb.sv
// Rotating-priority find-first: grants the first requester at or after ptr_i,
// wrapping at N. Pure combinational.
module gpc_rr_arb #(
    parameter int unsigned N     = 4,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    int unsigned j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            j = (int'(ptr_i) + i) % N;
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/gpc_thread_pc_sched.sv
// N-thread round-robin fetch scheduler with per-thread PC bank; applies Q101H
// redirects/replays to the owning thread and carries thread IDs to Q103H.
module gpc_thread_pc_sched
    import gpc_4t_pkg::*;
#(
    parameter int unsigned      NUM_THREADS      = 4,
    parameter int unsigned      PC_W             = 32,
    parameter logic [PC_W-1:0]  RESET_PC         = PC_W'(DEF_RESET_PC),
    parameter logic [PC_W-1:0]  THREAD_PC_STRIDE = PC_W'(DEF_PC_STRIDE),
    localparam int unsigned     TID_W            = $clog2(NUM_THREADS)
) (
    input  logic                        QClk,
    input  logic                        RstQnnnH,
    input  logic [NUM_THREADS-1:0]      ThreadEnQnnnH,
    input  logic [NUM_THREADS-1:0]      ThreadRstPcQnnnH,
    input  logic                        FetchReadyQ100H,
    output logic [PC_W-1:0]             PcQ100H,
    output logic [TID_W-1:0]            ThreadIdQ100H,
    output logic                        ValidQ100H,
    output logic                        ValidQ101H,
    output logic [TID_W-1:0]            ThreadIdQ101H,
    output logic [PC_W-1:0]             PcQ101H,
    output logic [TID_W-1:0]            ThreadIdQ102H,
    output logic                        ValidQ102H,
    output logic [TID_W-1:0]            ThreadIdQ103H,
    output logic                        ValidQ103H,
    input  logic                        RedirectQ101H,
    input  logic [PC_W-1:0]             RedirectPcQ101H,
    input  logic                        ReplayQ101H,
    output logic [NUM_THREADS*PC_W-1:0] PcBankQnnnH
);

    function automatic logic [PC_W-1:0] reset_pc(input int unsigned t);
        return RESET_PC + PC_W'(t) * THREAD_PC_STRIDE;
    endfunction

    logic [PC_W-1:0]        pc_q [NUM_THREADS];
    logic [PC_W-1:0]        pc_d [NUM_THREADS];
    logic [TID_W-1:0]       rr_q, rr_d;
    logic [PC_W-1:0]        pc100_q, pc100_d;
    logic [TID_W-1:0]       tid100_q, tid100_d;
    logic                   v101_q, v101_d;
    logic [TID_W-1:0]       tid101_q, tid101_d;
    logic [PC_W-1:0]        pc101_q, pc101_d;
    t_pipe_tag              q102_q, q102_d, q103_q, q103_d;

    logic [NUM_THREADS-1:0] owner_oh, req, gnt;
    logic [TID_W-1:0]       sel;
    logic                   any, issue, replay, redirect;

    // A thread sitting valid in Q101H may not fetch again until it leaves.
    assign owner_oh = v101_q ? (NUM_THREADS'(1) << tid101_q) : '0;
    assign req      = ThreadEnQnnnH & ~owner_oh;
    assign replay   = v101_q && ReplayQ101H;
    assign redirect = v101_q && RedirectQ101H;

    gpc_rr_arb #(
        .N(NUM_THREADS)
    ) u_rr_arb (
        .req_i(req),
        .ptr_i(rr_q),
        .gnt_o(gnt),
        .idx_o(sel),
        .any_o(any)
    );

    always_comb begin
        ValidQ100H    = any;
        PcQ100H       = any ? pc_q[sel] : pc100_q;
        ThreadIdQ100H = any ? sel : tid100_q;
        issue         = any && FetchReadyQ100H;

        pc100_d  = PcQ100H;
        tid100_d = ThreadIdQ100H;
        rr_d     = rr_q;
        if (issue) begin
            rr_d = (sel == TID_W'(NUM_THREADS - 1)) ? '0 : sel + TID_W'(1);
        end

        v101_d   = issue;
        tid101_d = issue ? sel : tid101_q;
        pc101_d  = issue ? PcQ100H : pc101_q;

        q102_d.valid = v101_q && !replay;
        q102_d.tid   = t_tid'(tid101_q);
        q103_d       = q102_q;

        for (int unsigned t = 0; t < NUM_THREADS; t++) begin
            if (ThreadRstPcQnnnH[t]) begin
                pc_d[t] = reset_pc(t);
            end else if (owner_oh[t] && replay) begin
                pc_d[t] = pc101_q;
            end else if (owner_oh[t] && redirect) begin
                pc_d[t] = {RedirectPcQ101H[PC_W-1:2], 2'b00};
            end else if (issue && gnt[t]) begin
                pc_d[t] = pc_q[t] + PC_W'(4);
            end else begin
                pc_d[t] = pc_q[t];
            end
        end
    end

    always_ff @(posedge QClk or negedge RstQnnnH) begin
        if (!RstQnnnH) begin
            for (int unsigned t = 0; t < NUM_THREADS; t++) pc_q[t] <= reset_pc(t);
            rr_q     <= '0;
            pc100_q  <= RESET_PC;
            tid100_q <= '0;
            v101_q   <= 1'b0;
            tid101_q <= '0;
            pc101_q  <= '0;
            q102_q   <= '0;
            q103_q   <= '0;
        end else begin
            for (int unsigned t = 0; t < NUM_THREADS; t++) pc_q[t] <= pc_d[t];
            rr_q     <= rr_d;
            pc100_q  <= pc100_d;
            tid100_q <= tid100_d;
            v101_q   <= v101_d;
            tid101_q <= tid101_d;
            pc101_q  <= pc101_d;
            q102_q   <= q102_d;
            q103_q   <= q103_d;
        end
    end

    assign ValidQ101H    = v101_q;
    assign ThreadIdQ101H = tid101_q;
    assign PcQ101H       = pc101_q;
    assign ValidQ102H    = q102_q.valid;
    assign ThreadIdQ102H = q102_q.tid[TID_W-1:0];
    assign ValidQ103H    = q103_q.valid;
    assign ThreadIdQ103H = q103_q.tid[TID_W-1:0];

    always_comb begin
        PcBankQnnnH = '0;
        for (int unsigned t = 0; t < NUM_THREADS; t++) begin
            PcBankQnnnH[t*PC_W +: PC_W] = pc_q[t];
        end
    end

endmodule

// File: tb/tb_gpc_thread_pc_sched.sv
// Directed plus random bench for gpc_thread_pc_sched, checked against a
// cycle-level behavioural model of the scheduler kept in arrays.
module tb_gpc_thread_pc_sched;

    localparam int NT = 4;

    logic          QClk = 1'b0;
    logic          RstQnnnH;
    logic [NT-1:0] en, rstpc;
    logic          ready, redir, replay;
    logic [31:0]   redir_pc;
    logic [31:0]   PcQ100H, PcQ101H;
    logic [1:0]    ThreadIdQ100H, ThreadIdQ101H, ThreadIdQ102H, ThreadIdQ103H;
    logic          ValidQ100H, ValidQ101H, ValidQ102H, ValidQ103H;
    logic [NT*32-1:0] PcBankQnnnH;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [31:0] m_pc [NT];
    int          m_rr;
    bit          m_v101, m_v102, m_v103;
    int          m_t101, m_t102, m_t103;
    logic [31:0] m_pc101;
    logic [31:0] m_hold_pc;
    int          m_hold_t;

    gpc_thread_pc_sched u_dut (
        .QClk(QClk),
        .RstQnnnH(RstQnnnH),
        .ThreadEnQnnnH(en),
        .ThreadRstPcQnnnH(rstpc),
        .FetchReadyQ100H(ready),
        .PcQ100H(PcQ100H),
        .ThreadIdQ100H(ThreadIdQ100H),
        .ValidQ100H(ValidQ100H),
        .ValidQ101H(ValidQ101H),
        .ThreadIdQ101H(ThreadIdQ101H),
        .PcQ101H(PcQ101H),
        .ThreadIdQ102H(ThreadIdQ102H),
        .ValidQ102H(ValidQ102H),
        .ThreadIdQ103H(ThreadIdQ103H),
        .ValidQ103H(ValidQ103H),
        .RedirectQ101H(redir),
        .RedirectPcQ101H(redir_pc),
        .ReplayQ101H(replay),
        .PcBankQnnnH(PcBankQnnnH)
    );

    always #5 QClk = ~QClk;

    function automatic logic [31:0] rst_pc_of(input int t);
        return 32'h0 + t * 32'h400;
    endfunction

    function automatic logic [127:0] m_bank();
        return {m_pc[3], m_pc[2], m_pc[1], m_pc[0]};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int t = 0; t < NT; t++) m_pc[t] = rst_pc_of(t);
        m_rr = 0;
        m_v101 = 0; m_v102 = 0; m_v103 = 0;
        m_t101 = 0; m_t102 = 0; m_t103 = 0;
        m_pc101 = 0;
        m_hold_pc = 32'h0;
        m_hold_t = 0;
    endtask

    task automatic check_reset_values();
        check("rst_v100", ValidQ100H, 0);
        check("rst_v101", ValidQ101H, 0);
        check("rst_v102", ValidQ102H, 0);
        check("rst_v103", ValidQ103H, 0);
        check("rst_pc100", PcQ100H, 32'h0);
        check("rst_pc101", PcQ101H, 32'h0);
        check("rst_tids", {ThreadIdQ100H, ThreadIdQ101H, ThreadIdQ102H, ThreadIdQ103H}, 0);
        check("rst_bank", PcBankQnnnH, {32'hC00, 32'h800, 32'h400, 32'h0});
    endtask

    // One clock: drive inputs after negedge, check against model, advance model at posedge.
    task automatic do_cycle(input logic [NT-1:0] e, input logic [NT-1:0] rp, input logic rdy,
                            input logic rd, input logic [31:0] rdpc, input logic rpl);
        bit          found = 0;
        int          sel = 0;
        bit          issue;
        logic [31:0] exp_pc100;
        int          exp_t100;
        logic [31:0] nxt [NT];
        en = e; rstpc = rp; ready = rdy; redir = rd; redir_pc = rdpc; replay = rpl;
        #1;
        for (int k = 0; k < NT; k++) begin
            int t = (m_rr + k) % NT;
            if (!found && e[t] && !(m_v101 && m_t101 == t)) begin
                found = 1;
                sel = t;
            end
        end
        exp_pc100 = found ? m_pc[sel] : m_hold_pc;
        exp_t100  = found ? sel : m_hold_t;
        check("v100", ValidQ100H, found);
        check("pc100", PcQ100H, exp_pc100);
        check("tid100", ThreadIdQ100H, exp_t100);
        check("v101", ValidQ101H, m_v101);
        if (m_v101) begin
            check("tid101", ThreadIdQ101H, m_t101);
            check("pc101", PcQ101H, m_pc101);
        end
        check("v102", ValidQ102H, m_v102);
        if (m_v102) check("tid102", ThreadIdQ102H, m_t102);
        check("v103", ValidQ103H, m_v103);
        if (m_v103) check("tid103", ThreadIdQ103H, m_t103);
        check("bank", PcBankQnnnH, m_bank());

        @(posedge QClk);
        issue = found && rdy;
        for (int t = 0; t < NT; t++) begin
            bit own = m_v101 && (m_t101 == t);
            if (rp[t])            nxt[t] = rst_pc_of(t);
            else if (own && rpl)  nxt[t] = m_pc101;
            else if (own && rd)   nxt[t] = rdpc & 32'hFFFF_FFFC;
            else if (issue && sel == t) nxt[t] = m_pc[t] + 32'd4;
            else                  nxt[t] = m_pc[t];
        end
        for (int t = 0; t < NT; t++) m_pc[t] = nxt[t];
        m_v103 = m_v102; m_t103 = m_t102;
        m_v102 = m_v101 && !rpl; m_t102 = m_t101;
        m_v101 = issue;
        if (issue) begin
            m_t101 = sel;
            m_pc101 = exp_pc100;
            m_rr = (sel + 1) % NT;
        end
        if (found) begin
            m_hold_pc = exp_pc100;
            m_hold_t = exp_t100;
        end
        @(negedge QClk);
    endtask

    initial begin
        RstQnnnH = 1'b0;
        en = '0; rstpc = '0; ready = 1'b0; redir = 1'b0; replay = 1'b0; redir_pc = '0;
        model_reset();
        #12;
        check_reset_values();
        @(negedge QClk);
        RstQnnnH = 1'b1;

        // All threads round-robin; replay thread 0 at 0x004, redirect thread 1 at 0x404
        for (int i = 0; i < 5; i++) do_cycle(4'hF, 4'h0, 1, 0, 0, 0);
        check("q101_t0_pc", {ValidQ101H, PcQ101H}, {1'b1, 32'h004});
        do_cycle(4'hF, 4'h0, 1, 0, 0, 1);
        check("replay_kill", ValidQ102H, 1'b0);
        check("replay_pc0", PcBankQnnnH[31:0], 32'h004);
        do_cycle(4'hF, 4'h0, 1, 1, 32'h1003, 0);
        check("redir_pc1", PcBankQnnnH[63:32], 32'h1000);
        check("redir_pc3", PcBankQnnnH[127:96], 32'hC04);
        for (int i = 0; i < 3; i++) do_cycle(4'hF, 4'h0, 1, 0, 0, 0);
        // Thread 1 now in Q101H: reload beats redirect
        check("t1_in_q101", {ValidQ101H, ThreadIdQ101H}, {1'b1, 2'd1});
        do_cycle(4'hF, 4'h2, 1, 1, 32'h2000, 0);
        check("rstpc_wins", PcBankQnnnH[63:32], 32'h400);

        // Fetch stall with only thread 0 enabled
        do_cycle(4'h1, 4'h0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) do_cycle(4'h1, 4'h0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) do_cycle(4'h1, 4'h0, 1, 0, 0, 0);

        // Async reset pulse mid-cycle
        en = '0; ready = 1'b0; redir = 1'b0; replay = 1'b0; rstpc = '0;
        #2;
        RstQnnnH = 1'b0;
        #1;
        check_reset_values();
        model_reset();
        @(negedge QClk);
        RstQnnnH = 1'b1;

        // Single thread 2: issues every other cycle
        for (int i = 0; i < 6; i++) do_cycle(4'h4, 4'h0, 1, 0, 0, 0);
        check("t2_pc", PcBankQnnnH[95:64], 32'h80C);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            do_cycle(NT'($urandom), ($urandom_range(0, 15) == 0) ? NT'($urandom) : '0,
                     $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom,
                     $urandom_range(0, 6) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
